// File: rtl/arbitro_ram_if.sv
// ---------------------------------------------------------------------------
// arbitro_ram_if : player request/grant, clear control and RAM write-port bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface arbitro_ram_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              clear_req;
  logic              j1_req;
  logic [ADDR_W-1:0] j1_addr;
  logic [DATA_W-1:0] j1_data;
  logic              j1_grant;
  logic              j2_req;
  logic [ADDR_W-1:0] j2_addr;
  logic [DATA_W-1:0] j2_data;
  logic              j2_grant;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddress;
  logic [DATA_W-1:0] ram_data;
  logic              clear_busy;
  logic              clear_done;
  logic              addr_err;

  modport slave (
    input  clear_req, j1_req, j1_addr, j1_data, j2_req, j2_addr, j2_data,
    output j1_grant, j2_grant, ram_wren, ram_wraddress, ram_data,
           clear_busy, clear_done, addr_err
  );

  modport master (
    output clear_req, j1_req, j1_addr, j1_data, j2_req, j2_addr, j2_data,
    input  j1_grant, j2_grant, ram_wren, ram_wraddress, ram_data,
           clear_busy, clear_done, addr_err
  );
endinterface

`default_nettype wire

// File: rtl/arbitro_ram.sv
// ---------------------------------------------------------------------------
// arbitro_ram : trail RAM write-port owner; clear sweep + round-robin players
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arbitro_ram #(
  parameter int                N_PIXELS    = 307200,
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  wire logic    CLOCK_50,
  input  wire logic    reset,
  arbitro_ram_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              last_j2_q, last_j2_d;
  logic              clr_prev_q, clr_prev_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              clr_rise;
  logic              gnt1, gnt2;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_j2_d  = last_j2_q;
    clr_prev_d = bus.clear_req;
    wren_d     = 1'b0;
    waddr_d    = waddr_q;
    data_d     = data_q;
    err_d      = 1'b0;
    gnt1       = 1'b0;
    gnt2       = 1'b0;
    sel_addr   = bus.j1_addr;
    sel_data   = bus.j1_data;
    clr_rise   = bus.clear_req && !clr_prev_q;

    if (state_q == ST_CLEAR) begin
      wren_d  = 1'b1;
      waddr_d = ptr_q;
      data_d  = CLEAR_VALUE;
      if (ptr_q == LAST_ADDR) begin
        ptr_d   = '0;
        state_d = ST_IDLE;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else if (clr_rise) begin
      state_d = ST_CLEAR;
    end else if (!busy_q) begin
      // busy_q still high means the final sweep word is on the outputs
      gnt1 = bus.j1_req && (!bus.j2_req || last_j2_q);
      gnt2 = bus.j2_req && !gnt1;
      if (gnt2) begin
        sel_addr = bus.j2_addr;
        sel_data = bus.j2_data;
      end
      if (gnt1 || gnt2) begin
        last_j2_d = gnt2;
        if (sel_addr > LAST_ADDR) begin
          err_d = 1'b1;
        end else begin
          wren_d  = 1'b1;
          waddr_d = sel_addr;
          data_d  = sel_data;
        end
      end
    end

    // Busy spans the CLEAR state plus the cycle showing the last sweep word
    busy_d = (state_d == ST_CLEAR) || (state_q == ST_CLEAR);
    done_d = busy_q && !busy_d;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      last_j2_q  <= 1'b1;
      clr_prev_q <= 1'b1;
      wren_q     <= 1'b0;
      waddr_q    <= '0;
      data_q     <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      last_j2_q  <= last_j2_d;
      clr_prev_q <= clr_prev_d;
      wren_q     <= wren_d;
      waddr_q    <= waddr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.j1_grant      = gnt1;
  assign bus.j2_grant      = gnt2;
  assign bus.ram_wren      = wren_q;
  assign bus.ram_wraddress = waddr_q;
  assign bus.ram_data      = data_q;
  assign bus.clear_busy    = busy_q;
  assign bus.clear_done    = done_q;
  assign bus.addr_err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_arbitro_ram.sv
// ---------------------------------------------------------------------------
// tb_arbitro_ram : vector table + write scoreboard bench, reduced screen size
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arbitro_ram;
  localparam int N  = 1000;
  localparam int NV = 14;

  typedef struct {
    logic        wren;
    logic [18:0] addr;
    logic [7:0]  data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        j1r;
    logic [18:0] j1a;
    logic [7:0]  j1d;
    logic        j2r;
    logic [18:0] j2a;
    logic [7:0]  j2d;
    logic        g1;
    logic        g2;
    logic        wr;
    logic [18:0] wa;
    logic [7:0]  wd;
    logic        er;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  always #10 clk = ~clk;

  arbitro_ram_if #(.ADDR_W(19), .DATA_W(8)) bus ();

  arbitro_ram #(
    .N_PIXELS(N), .ADDR_W(19), .DATA_W(8), .CLEAR_VALUE(8'h00)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    check({nm, " ram_wren"}, bus.ram_wren, 0);
    check({nm, " ram_wraddress"}, bus.ram_wraddress, 0);
    check({nm, " ram_data"}, bus.ram_data, 0);
    check({nm, " clear_busy"}, bus.clear_busy, 1);
    check({nm, " clear_done"}, bus.clear_done, 0);
    check({nm, " addr_err"}, bus.addr_err, 0);
    check({nm, " j1_grant"}, bus.j1_grant, 0);
  endtask

  // One cycle: grants checked against eg1/eg2, RAM outputs against the queue head.
  task automatic cyc(input string nm, input logic eg1, input logic eg2,
                     input logic do_push, input exp_t nx);
    exp_t e;
    @(negedge clk);
    check({nm, " j1_grant"}, bus.j1_grant, eg1);
    check({nm, " j2_grant"}, bus.j2_grant, eg2);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({nm, " ram_wren"}, bus.ram_wren, e.wren);
      check({nm, " addr_err"}, bus.addr_err, e.err);
      if (e.wren) begin
        check({nm, " ram_wraddress"}, bus.ram_wraddress, e.addr);
        check({nm, " ram_data"}, bus.ram_data, e.data);
      end
    end
    if (do_push) sb.push_back(nx);
    @(posedge clk);
    #1;
  endtask

  // Expects the next negedge to show sweep word 0; returns at the clear_done negedge.
  task automatic sweep_check(input string nm, input logic toggle_clr);
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (bus.ram_wren !== 1'b1 || bus.ram_wraddress !== 19'(i) ||
          bus.ram_data !== 8'h00 || bus.clear_busy !== 1'b1 ||
          bus.clear_done !== 1'b0 || bus.j1_grant !== 1'b0 || bus.j2_grant !== 1'b0)
        bad++;
      if (toggle_clr && i == 100) bus.clear_req = 1'b0;
      if (toggle_clr && i == 200) bus.clear_req = 1'b1;
    end
    check({nm, " bad sweep words"}, bad, 0);
    @(negedge clk);
    check({nm, " done pulse"}, bus.clear_done, 1);
    check({nm, " busy low"}, bus.clear_busy, 0);
    check({nm, " wren low"}, bus.ram_wren, 0);
  endtask

  initial begin
    exp_t nx;
    exp_t zero;
    logic found;
    zero = '{1'b0, 19'd0, 8'h00, 1'b0};

    vecs[0]  = '{1'b0, 19'd0,    8'h00, 1'b0, 19'd0,    8'h00, 1'b0, 1'b0, 1'b0, 19'd0,   8'h00, 1'b0};
    vecs[1]  = '{1'b1, 19'd500,  8'h01, 1'b0, 19'd0,    8'h00, 1'b1, 1'b0, 1'b1, 19'd500, 8'h01, 1'b0};
    vecs[2]  = '{1'b0, 19'd0,    8'h00, 1'b1, 19'd7,    8'h77, 1'b0, 1'b1, 1'b1, 19'd7,   8'h77, 1'b0};
    vecs[3]  = '{1'b0, 19'd0,    8'h00, 1'b1, 19'd8,    8'h88, 1'b0, 1'b1, 1'b1, 19'd8,   8'h88, 1'b0};
    vecs[4]  = '{1'b1, 19'd100,  8'hAA, 1'b1, 19'd200,  8'hBB, 1'b1, 1'b0, 1'b1, 19'd100, 8'hAA, 1'b0};
    vecs[5]  = '{1'b1, 19'd100,  8'hAA, 1'b1, 19'd200,  8'hBB, 1'b0, 1'b1, 1'b1, 19'd200, 8'hBB, 1'b0};
    vecs[6]  = '{1'b1, 19'd100,  8'hAA, 1'b1, 19'd200,  8'hBB, 1'b1, 1'b0, 1'b1, 19'd100, 8'hAA, 1'b0};
    vecs[7]  = '{1'b1, 19'd100,  8'hAA, 1'b1, 19'd200,  8'hBB, 1'b0, 1'b1, 1'b1, 19'd200, 8'hBB, 1'b0};
    vecs[8]  = '{1'b1, 19'd1000, 8'h55, 1'b0, 19'd0,    8'h00, 1'b1, 1'b0, 1'b0, 19'd0,   8'h00, 1'b1};
    vecs[9]  = '{1'b1, 19'd999,  8'h66, 1'b0, 19'd0,    8'h00, 1'b1, 1'b0, 1'b1, 19'd999, 8'h66, 1'b0};
    vecs[10] = '{1'b0, 19'd0,    8'h00, 1'b1, 19'd1023, 8'h12, 1'b0, 1'b1, 1'b0, 19'd0,   8'h00, 1'b1};
    vecs[11] = '{1'b1, 19'd300,  8'h11, 1'b1, 19'd300,  8'h22, 1'b1, 1'b0, 1'b1, 19'd300, 8'h11, 1'b0};
    vecs[12] = '{1'b1, 19'd300,  8'h11, 1'b1, 19'd300,  8'h22, 1'b0, 1'b1, 1'b1, 19'd300, 8'h22, 1'b0};
    vecs[13] = '{1'b0, 19'd0,    8'h00, 1'b0, 19'd0,    8'h00, 1'b0, 1'b0, 1'b0, 19'd0,   8'h00, 1'b0};

    bus.clear_req = 1'b0;
    bus.j1_req = 1'b1; bus.j1_addr = 19'd600; bus.j1_data = 8'h3C;
    bus.j2_req = 1'b0; bus.j2_addr = 19'd0;   bus.j2_data = 8'h00;

    // Power-on reset, then the automatic sweep with J1 waiting throughout
    #25;
    chk_reset("por");
    @(negedge clk) rst = 1'b0;
    sweep_check("sweep1", 1'b0);
    check("sweep1 done j1_grant", bus.j1_grant, 1);
    sb.push_back('{1'b1, 19'd600, 8'h3C, 1'b0});
    @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) begin
      bus.j1_req = vecs[v].j1r; bus.j1_addr = vecs[v].j1a; bus.j1_data = vecs[v].j1d;
      bus.j2_req = vecs[v].j2r; bus.j2_addr = vecs[v].j2a; bus.j2_data = vecs[v].j2d;
      nx = '{vecs[v].wr, vecs[v].wa, vecs[v].wd, vecs[v].er};
      cyc($sformatf("vec%0d", v), vecs[v].g1, vecs[v].g2, 1'b1, nx);
    end

    // Clear request while J2 holds a request: no grant until clear_done
    bus.j2_req = 1'b1; bus.j2_addr = 19'd42; bus.j2_data = 8'h05;
    bus.clear_req = 1'b1;
    cyc("clr detect", 1'b0, 1'b0, 1'b0, zero);
    @(negedge clk);
    check("clr+1 wren", bus.ram_wren, 0);
    check("clr+1 busy", bus.clear_busy, 1);
    check("clr+1 j2_grant", bus.j2_grant, 0);
    sweep_check("sweep2", 1'b1);
    check("sweep2 done j2_grant", bus.j2_grant, 1);
    check("sweep2 done j1_grant", bus.j1_grant, 0);
    sb.push_back('{1'b1, 19'd42, 8'h05, 1'b0});
    @(posedge clk);
    #1;
    bus.j2_req = 1'b0;
    cyc("post-clear j2 write", 1'b0, 1'b0, 1'b1, zero);
    bus.clear_req = 1'b0;
    cyc("clr low", 1'b0, 1'b0, 1'b0, zero);
    bus.clear_req = 1'b1;
    cyc("clr rise 2", 1'b0, 1'b0, 1'b0, zero);

    // Asynchronous reset in the middle of a sweep
    found = 1'b0;
    for (int k = 0; k < 2 * N && !found; k++) begin
      @(negedge clk);
      if (bus.ram_wren === 1'b1 && bus.ram_wraddress === 19'd500) found = 1'b1;
    end
    check("reach sweep addr 500", found, 1);
    if (found) begin
      #2 rst = 1'b1;
      #1 chk_reset("mid-sweep reset");
      @(negedge clk) rst = 1'b0;
      sweep_check("sweep3", 1'b0);
    end

    check("scoreboard empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
